ex_muldiv: RTL
==============

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_arst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request a mul/div this cycle, from execute decode.
REQ-005 SHALL have port i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port i_rs  input  DATA_WIDTH  multiplicand or dividend.
REQ-007 SHALL have port i_rt  input  DATA_WIDTH  multiplier or divisor.
REQ-008 SHALL have ports i_mthi and i_mtlo  input  1 each  write i_rs into HI or LO.
REQ-009 SHALL have port i_hilo_rd  input  1  MFHI/MFLO present in execute.
REQ-010 SHALL have port i_kill  input  1  abort from coprocessor (interrupt/exception).
REQ-011 SHALL have port o_busy  output  1  iteration in progress.
REQ-012 SHALL have port o_stall  output  1  pipeline hold request to fetch/decode/execute.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse: HI/LO just updated by an operation.
REQ-014 SHALL have ports o_hi and o_lo  output  DATA_WIDTH each  architectural HI and LO.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-016 IDLE: i_start and not i_kill at an edge -> MUL (i_op[1]=0) or DIV (i_op[1]=1); operands latched as magnitudes (signed ops) or raw (unsigned); result signs recorded.
REQ-017 MUL and DIV SHALL each run exactly 32 radix-2 iterations via a 6-bit counter, then -> FIX.
REQ-018 FIX SHALL apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write HI/LO, pulse o_done, -> IDLE.
REQ-019 Latency: start sampled at edge E0; HI/LO updated at edge E33; o_done high in cycle after E33 only.
REQ-020 o_busy SHALL be high in every cycle from after E0 up to but excluding the cycle after E33.
REQ-021 o_stall SHALL equal o_busy AND (i_hilo_rd OR i_start), combinational.
REQ-022 i_start while o_busy SHALL be ignored (stall holds the instruction).
REQ-023 MULT/MULTU: {HI,LO} = full 64-bit product, signed or unsigned per i_op.
REQ-024 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder.
REQ-025 Divide by zero (signed or unsigned): LO = all ones, HI = i_rs, same 34-edge latency.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
REQ-027 i_mthi/i_mtlo in IDLE SHALL write i_rs to HI/LO at next edge, no o_done; ignored when busy.
REQ-028 i_start and i_mthi/i_mtlo same cycle in IDLE: start wins, move ignored.
REQ-029 i_kill in any non-IDLE state SHALL return FSM to IDLE at next edge, HI/LO unchanged, no o_done.
REQ-030 i_kill same cycle as i_start in IDLE: start and moves ignored.
REQ-031 HI/LO SHALL change only at FIX exit, accepted mthi/mtlo, or reset.

Reset
REQ-032 i_arst high SHALL immediately force FSM IDLE, counter 0, o_hi=0, o_lo=0, o_busy=0, o_done=0, internal operand registers 0.
REQ-033 Reset mid-operation SHALL discard the operation; first edge after release behaves as IDLE.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, o_done exactly 34 edges after start edge counting E0 as edge 1, o_busy high 33 cycles.
REQ-035 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-036 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 MTHI 0x12345678 then MULTU 2x3 with i_kill at iteration 10 -> o_busy low next cycle, HI=0x12345678 retained, no o_done; second i_start during busy ignored.
REQ-038 i_hilo_rd high while busy -> o_stall=1 until o_done cycle; i_hilo_rd in IDLE -> o_stall=0.
REQ-039 i_arst asserted at iteration 20 -> all outputs 0 asynchronously; fresh DIVU 100/7 afterwards -> LO=14, HI=2.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide over magnitudes, sign fixed at the end.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0] i_rt,
    input  logic                  i_mthi,
    input  logic                  i_mtlo,
    input  logic                  i_hilo_rd,
    input  logic                  i_kill,
    output logic                  o_busy,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W = DATA_WIDTH;
    localparam logic [5:0] LAST = 6'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t state;
    state_t state_nx;

    logic [5:0]   cnt;
    logic [W-1:0] opnd;
    logic [W-1:0] acc_hi;
    logic [W-1:0] acc_lo;
    logic         is_div;
    logic         neg_lo;
    logic         neg_hi;
    logic         div_zero;
    logic         go;
    logic         mv_ok;

    logic         signed_op;
    logic         rs_neg;
    logic         rt_neg;
    logic [W-1:0] rs_mag;
    logic [W-1:0] rt_mag;

    logic [W:0]     msum;
    logic [W:0]     dshift;
    logic [W:0]     dsub;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    assign signed_op = ~i_op[0];
    assign rs_neg    = signed_op & i_rs[W-1];
    assign rt_neg    = signed_op & i_rt[W-1];
    assign rs_mag    = rs_neg ? -i_rs : i_rs;
    assign rt_mag    = rt_neg ? -i_rt : i_rt;

    assign msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign dshift = {acc_hi, acc_lo[W-1]};
    assign dsub   = dshift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_lo ? -prod : prod;
    assign q_fix    = div_zero ? '1 : (neg_lo ? -acc_lo : acc_lo);
    assign r_fix    = neg_hi ? -acc_hi : acc_hi;
    assign res_hi   = is_div ? r_fix : prod_fix[2*W-1:W];
    assign res_lo   = is_div ? q_fix : prod_fix[W-1:0];

    assign o_stall = o_busy & (i_hilo_rd | i_start);

    // State register.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, busy flag, and IDLE-side accept decisions.
    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        go       = 1'b0;
        mv_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start && !i_kill) begin
                    go       = 1'b1;
                    state_nx = i_op[1] ? DIV : MUL;
                end else if (!i_start && !i_kill) begin
                    mv_ok = 1'b1;
                end
            end
            MUL, DIV: begin
                o_busy = 1'b1;
                if (i_kill)          state_nx = IDLE;
                else if (cnt == LAST) state_nx = FIX;
            end
            FIX: begin
                o_busy   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch at start, then one shift-add or shift-subtract step per cycle.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else if (go) begin
            cnt      <= '0;
            is_div   <= i_op[1];
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= rs_neg;
            div_zero <= (i_rt == '0);
            acc_hi   <= '0;
            if (i_op[1]) begin
                opnd   <= rt_mag;
                acc_lo <= rs_mag;
            end else begin
                opnd   <= rs_mag;
                acc_lo <= rt_mag;
            end
        end else if (state == MUL) begin
            acc_hi <= msum[W:1];
            acc_lo <= {msum[0], acc_lo[W-1:1]};
            cnt    <= cnt + 6'd1;
        end else if (state == DIV) begin
            if (!dsub[W]) begin
                acc_hi <= dsub[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b1};
            end else begin
                acc_hi <= dshift[W-1:0];
                acc_lo <= {acc_lo[W-2:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
        end
    end

    // Architectural HI/LO: written by a finished operation or an accepted move.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_hi <= '0;
            o_lo <= '0;
        end else if (state == FIX && !i_kill) begin
            o_hi <= res_hi;
            o_lo <= res_lo;
        end else if (mv_ok) begin
            if (i_mthi) o_hi <= i_rs;
            if (i_mtlo) o_lo <= i_rs;
        end
    end

    // Completion pulse, one cycle after the HI/LO write.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) o_done <= 1'b0;
        else        o_done <= (state == FIX) && !i_kill;
    end

endmodule
